// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS mode encoding, fixed symbols and helper functions
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VID_GB = 3'd2,
        MODE_TERC4  = 3'd3,
        MODE_DI_GB  = 3'd4
    } mode_e;

    localparam logic [9:0] CTL0  = 10'b1101010100;
    localparam logic [9:0] CTL1  = 10'b0010101011;
    localparam logic [9:0] CTL2  = 10'b0101010100;
    localparam logic [9:0] CTL3  = 10'b1010101011;
    localparam logic [9:0] VGB_0 = 10'b1011001100;
    localparam logic [9:0] VGB_1 = 10'b0100110011;
    localparam logic [9:0] DGB   = 10'b0100110011;

    function automatic logic [9:0] terc4(input logic [3:0] d);
        logic [9:0] s;
        case (d)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, d[i]};
        return c;
    endfunction

    function automatic logic [4:0] popcount10(input logic [9:0] d);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 10; i++) c = c + {4'b0000, d[i]};
        return c;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// rtl/tmds_lane.sv - one TMDS lane: stage-1 transition minimisation, stage-2 DC balance
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int LANE_IDX = 0,
    parameter int RD_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [2:0] mode,
    input  logic [7:0] vd,
    input  logic [1:0] cd,
    input  logic [3:0] aux,
    output logic [9:0] tmds
);

    mode_e            mode_n;
    logic [3:0]       n1_vd;
    logic             use_xnor;
    logic [8:0]       qm_d, qm_q;
    logic [3:0]       n1qm_d, n1qm_q;
    logic [9:0]       sym_d, sym_q;
    mode_e            mode_q;

    logic             invert;
    logic [4:0]       ones;
    logic [9:0]       tmds_d, tmds_q;
    logic [RD_W-1:0]  rd_d, rd_q;

    always_comb begin
        mode_n   = (mode > 3'd4) ? MODE_CTRL : mode_e'(mode);
        n1_vd    = popcount8(vd);
        use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !vd[0]);
        qm_d     = '0;
        qm_d[0]  = vd[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ vd[i]) : (qm_d[i-1] ^ vd[i]);
        qm_d[8]  = ~use_xnor;
        n1qm_d   = popcount8(qm_d[7:0]);
        case (mode_n)
            MODE_VID_GB: sym_d = (LANE_IDX % 3 == 1) ? VGB_1 : VGB_0;
            MODE_TERC4:  sym_d = terc4(aux);
            MODE_DI_GB:  sym_d = (LANE_IDX % 3 == 0) ? terc4(aux) : DGB;
            default: begin
                case (cd)
                    2'b00:   sym_d = CTL0;
                    2'b01:   sym_d = CTL1;
                    2'b10:   sym_d = CTL2;
                    default: sym_d = CTL3;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm_q   <= '0;
            n1qm_q <= '0;
            sym_q  <= CTL0;
            mode_q <= MODE_CTRL;
        end else if (ce) begin
            qm_q   <= qm_d;
            n1qm_q <= n1qm_d;
            sym_q  <= sym_d;
            mode_q <= mode_n;
        end
    end

    // Non-video symbols pass through and restart the disparity at zero.
    always_comb begin
        tmds_d = sym_q;
        rd_d   = '0;
        invert = 1'b0;
        ones   = '0;
        if (mode_q == MODE_VIDEO) begin
            if ((rd_q == '0) || (n1qm_q == 4'd4)) begin
                tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            end else begin
                invert = (!rd_q[RD_W-1] && (n1qm_q > 4'd4)) ||
                         ( rd_q[RD_W-1] && (n1qm_q < 4'd4));
                tmds_d = {invert, qm_q[8], invert ? ~qm_q[7:0] : qm_q[7:0]};
            end
            ones = popcount10(tmds_d);
            rd_d = rd_q + RD_W'({ones, 1'b0}) - RD_W'(10);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds_q <= CTL0;
            rd_q   <= '0;
        end else if (ce) begin
            tmds_q <= tmds_d;
            rd_q   <= rd_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// rtl/tmds_multi_encoder.sv - NCH lock-step HDMI TMDS lanes with shared pipeline-valid flag
module tmds_multi_encoder
    import tmds_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int RD_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [2:0]        mode,
    input  logic [8*NCH-1:0]  vd,
    input  logic [2*NCH-1:0]  cd,
    input  logic [4*NCH-1:0]  aux,
    output logic [10*NCH-1:0] tmds,
    output logic              tmds_valid
);

    logic [1:0] valid_q, valid_d;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        tmds_lane #(
            .LANE_IDX (g),
            .RD_W     (RD_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .mode  (mode),
            .vd    (vd[8*g +: 8]),
            .cd    (cd[2*g +: 2]),
            .aux   (aux[4*g +: 4]),
            .tmds  (tmds[10*g +: 10])
        );
    end

    // Two-deep shift of ones tracks when real data reaches the lane outputs.
    assign valid_d = {valid_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (ce)
            valid_q <= valid_d;
    end

    assign tmds_valid = valid_q[1];

endmodule

// File: doc/tmds_multi_encoder.md
# tmds_multi_encoder

Parametrised multi-channel HDMI TMDS encoder and the successor to the single-channel DVI encoder. It sits between the pixel/timing generator and the serialisers, encodes NCH lanes in lock-step, and adds HDMI period types beyond plain DVI video and control: video guard bands, TERC4 data-island symbols and data-island guard bands. Each lane has a 2-stage pipeline and an independent running disparity. A clock enable allows operation from a divided pixel clock.

## Interface
Parameters:
- NCH, 3: number of TMDS lanes encoded in parallel (≥1).
- RD_W, 5: signed running-disparity width per lane (≥5).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, every register holds.
- mode  in  3  period type: 0 CTRL, 1 VIDEO, 2 VID_GB, 3 TERC4, 4 DI_GB; 5–7 behave as CTRL.
- vd  in  8*NCH  video byte per lane; lane i occupies [8i+7:8i].
- cd  in  2*NCH  control bits per lane, {c1,c0}; lane 0 carries {VSYNC,HSYNC}.
- aux  in  4*NCH  TERC4 nibble per lane.
- tmds  out  10*NCH  encoded symbol per lane, bit 0 transmitted first.
- tmds_valid  out  1  high once the pipeline holds post-reset data.

## Operation
- Every lane encodes according to the same mode each cycle.
- CTRL: cd 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- VIDEO: standard DVI 1.0 two-stage algorithm.
  - XNOR is used when n1(vd)>4, or when n1(vd)==4 and vd[0]==0. q_m[8] = ~use_xnor.
  - If rd==0 or n1(q_m[7:0])==4: q_out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
  - Else: invert q_m[7:0] when sign(rd) equals sign(n1−4); q_out[9] = invert; q_out[8] = q_m8.
  - rd_next = rd + 2·ones(q_out) − 10.
- VID_GB: the lane index i mod 3 selects the symbol: 0→1011001100, 1→0100110011, 2→1011001100.
- TERC4: aux nibble → HDMI 1.4 TERC4 table (16 entries).
- DI_GB: lane (i mod 3)==0 emits TERC4(aux); the other lanes emit 0100110011.
- Any mode other than VIDEO clears that lane's rd to 0 in stage 2.
- Arithmetic:
  - Popcounts are 4-bit (8 inputs) and 5-bit (10 inputs).
  - rd is RD_W-bit signed with no saturation; the algorithm bounds |rd| so it never wraps.
  - No multipliers; ×2 is a shift.

## Timing
- Latency is exactly 2 ce-qualified cycles from inputs to tmds.
- Stage 1 registers, per lane: q_m[8:0], n1(q_m[7:0]), the control or guard symbol, and mode.
- Stage 2 registers tmds and updates rd using stage-1 data and the current rd.
- ce low: stage 1, stage 2, rd and tmds_valid all hold. tmds keeps its last value.
- Reset (async assert, any time, including mid-VIDEO):
  - Every lane's tmds = 1101010100 (CTL0).
  - rd = 0; stage-1 mode = CTRL with cd = 00; tmds_valid = 0.
- tmds_valid rises after the second ce-qualified edge following reset release, then stays high.
- VIDEO→other→VIDEO: the first video symbol after the gap is encoded with rd = 0.
- Back-to-back mode changes need no idle cycle. Each symbol's encoding depends only on its own mode and the lane's rd.

## Structure
- Package tmds_pkg contains:
  - the mode_e enum (3-bit);
  - CTL0–CTL3, VGB_0/VGB_1 and DGB constants;
  - the function terc4(logic [3:0]) → logic [9:0];
  - the functions popcount8 and popcount10.
- Sub-module tmds_lane: one lane's 2-stage pipeline and rd. A lane-index parameter selects its guard-band behaviour.
- tmds_multi_encoder instantiates NCH tmds_lane via generate and owns tmds_valid.

## Test plan
- Reset: hold rst_n=0 → every lane tmds=1101010100 and tmds_valid=0. Release with ce=1 → tmds_valid=1 on the 2nd edge.
- CTRL: lane-0 cd=11, mode=CTRL → lane-0 tmds=1010101011 and lane 1 = 1101010100, 2 cycles later.
- VIDEO disparity: two consecutive vd=0x00 from rd=0 → tmds 0100000000 (rd −8), then 1111111111 (rd +2). Insert one CTRL cycle, then 0x00 → 0100000000 again.
- VID_GB with NCH=3 → lanes 0/1/2 = 1011001100 / 0100110011 / 1011001100. rd of each lane is 0 afterwards.
- TERC4 and DI_GB:
  - TERC4, aux=0x0 → 1010011100; aux=0xF → 1011000011.
  - DI_GB with lane-0 aux=0xC → lane 0 = TERC4(0xC); lanes 1 and 2 = 0100110011.
- ce gap and async reset:
  - Drop ce for 3 cycles mid-VIDEO → tmds and rd are frozen; the sequence resumes bit-exact against a ce-always-high reference model.
  - Assert rst_n mid-VIDEO → immediate CTL0 output and rd=0.
